// File: rtl/dino_jump_ctrl_if.sv
// rtl/dino_jump_ctrl_if.sv - control/sprite signal bundle for the dino jump controller
//
// Purpose: groups the per-frame control inputs and the sprite outputs of
// dino_jump_ctrl so the debouncer side and the renderer side share one bundle.
// Signals:
//   frame_tick  1-cycle pulse per video frame
//   jump        debounced jump button level
//   duck        debounced duck button level
//   freeze      game-over hold
//   dino_y      sprite origin Y (signed pixels)
//   select      4-bit pose code
//   airborne    high while the dino is in the air
// Modports:
//   master  drives the control inputs, observes the sprite outputs
//   slave   the controller itself
interface dino_jump_ctrl_if;
  logic        frame_tick;
  logic        jump;
  logic        duck;
  logic        freeze;
  logic [31:0] dino_y;
  logic [3:0]  select;
  logic        airborne;

  modport master (
    output frame_tick, jump, duck, freeze,
    input  dino_y, select, airborne
  );

  modport slave (
    input  frame_tick, jump, duck, freeze,
    output dino_y, select, airborne
  );
endinterface

// File: rtl/dino_jump_ctrl.sv
// rtl/dino_jump_ctrl.sv - per-frame vertical motion and pose controller for the T-Rex sprite
//
// Purpose: captures jump presses, integrates vertical velocity under gravity
// once per frame, runs the leg animation and produces the sprite origin Y and
// pose code for the renderer.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus     dino_jump_ctrl_if.slave:
//             frame_tick, jump, duck, freeze  (in)
//             dino_y, select, airborne        (out, registered)
module dino_jump_ctrl #(
  parameter int GROUND_Y    = 300,
  parameter int JUMP_V      = -20,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL_V  = 20,
  parameter int ANIM_FRAMES = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  dino_jump_ctrl_if.slave  bus
);

  localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  localparam logic signed [31:0] GROUND   = 32'(GROUND_Y);
  localparam logic signed [31:0] LAUNCH_Y = 32'(GROUND_Y + JUMP_V);
  localparam logic signed [10:0] LAUNCH_V = 11'(JUMP_V + GRAVITY);
  localparam logic signed [11:0] G_NORM   = 12'(GRAVITY);
  localparam logic signed [11:0] G_FAST   = 12'(3 * GRAVITY);
  localparam logic signed [11:0] V_CAP    = 12'(MAX_FALL_V);
  localparam logic [AW-1:0]      ANIM_LAST = AW'(ANIM_FRAMES - 1);

  localparam logic [3:0] SEL_RUN0  = 4'b0001;
  localparam logic [3:0] SEL_RUN1  = 4'b0010;
  localparam logic [3:0] SEL_DUCK0 = 4'b0100;
  localparam logic [3:0] SEL_DUCK1 = 4'b0101;
  localparam logic [3:0] SEL_AIR   = 4'b1010;
  localparam logic [3:0] SEL_DEAD  = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUCK = 2'd1,
    ST_AIR  = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic signed [31:0] y_q, y_nxt;
  logic signed [10:0] vel_q, vel_nxt;
  logic [AW-1:0]      anim_q, anim_nxt;
  logic               phase_q, phase_nxt;
  logic               jump_prev_q;
  logic               jump_pend_q, jump_pend_nxt;
  logic [3:0]         select_q, select_nxt;
  logic               airborne_q;

  logic               advance;
  logic               jump_rise;
  logic signed [31:0] vel_ext;
  logic signed [31:0] pos_step;
  logic signed [11:0] vel_sum;

  assign advance   = bus.frame_tick && !bus.freeze;
  assign jump_rise = bus.jump && !jump_prev_q;
  assign vel_ext   = {{21{vel_q[10]}}, vel_q};
  assign pos_step  = y_q + vel_ext;
  // One extra bit so the gravity add cannot wrap before the cap is applied.
  assign vel_sum   = {vel_q[10], vel_q} + (bus.duck ? G_FAST : G_NORM);

  // A press is remembered only until the next frame decision; freeze also
  // discards it so a press during game-over never launches afterwards.
  always_comb begin
    jump_pend_nxt = jump_pend_q;
    if (bus.freeze) begin
      jump_pend_nxt = 1'b0;
    end else if (jump_rise) begin
      jump_pend_nxt = 1'b1;
    end else if (bus.frame_tick) begin
      jump_pend_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    y_nxt     = y_q;
    vel_nxt   = vel_q;
    anim_nxt  = anim_q;
    phase_nxt = phase_q;

    if (advance) begin
      case (state_q)
        ST_RUN, ST_DUCK: begin
          if (anim_q == ANIM_LAST) begin
            anim_nxt  = '0;
            phase_nxt = ~phase_q;
          end else begin
            anim_nxt = anim_q + AW'(1);
          end

          if (jump_pend_q) begin
            state_nxt = ST_AIR;
            y_nxt     = LAUNCH_Y;
            vel_nxt   = LAUNCH_V;
            anim_nxt  = '0;
            phase_nxt = 1'b0;
          end else if (state_q == ST_RUN && bus.duck) begin
            state_nxt = ST_DUCK;
          end else if (state_q == ST_DUCK && !bus.duck) begin
            state_nxt = ST_RUN;
          end
        end

        ST_AIR: begin
          if (pos_step >= GROUND) begin
            // Landing tick never launches again, even with a press pending.
            y_nxt     = GROUND;
            vel_nxt   = '0;
            state_nxt = bus.duck ? ST_DUCK : ST_RUN;
          end else begin
            y_nxt   = (pos_step < 0) ? 32'sd0 : pos_step;
            vel_nxt = (vel_sum > V_CAP) ? V_CAP[10:0] : vel_sum[10:0];
          end
        end

        default: begin
          state_nxt = ST_RUN;
          y_nxt     = GROUND;
          vel_nxt   = '0;
          anim_nxt  = '0;
          phase_nxt = 1'b0;
        end
      endcase
    end
  end

  // Pose follows the post-update state so it lines up with dino_y.
  always_comb begin
    select_nxt = SEL_RUN0;
    if (bus.freeze) begin
      select_nxt = SEL_DEAD;
    end else begin
      case (state_nxt)
        ST_RUN:  select_nxt = phase_nxt ? SEL_RUN1 : SEL_RUN0;
        ST_DUCK: select_nxt = phase_nxt ? SEL_DUCK1 : SEL_DUCK0;
        ST_AIR:  select_nxt = SEL_AIR;
        default: select_nxt = SEL_RUN0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      y_q         <= GROUND;
      vel_q       <= '0;
      anim_q      <= '0;
      phase_q     <= 1'b0;
      jump_prev_q <= 1'b0;
      jump_pend_q <= 1'b0;
      select_q    <= SEL_RUN0;
      airborne_q  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      y_q         <= y_nxt;
      vel_q       <= vel_nxt;
      anim_q      <= anim_nxt;
      phase_q     <= phase_nxt;
      jump_prev_q <= bus.jump;
      jump_pend_q <= jump_pend_nxt;
      select_q    <= select_nxt;
      airborne_q  <= (state_nxt == ST_AIR);
    end
  end

  assign bus.dino_y   = y_q;
  assign bus.select   = select_q;
  assign bus.airborne = airborne_q;

endmodule
